cory_pack2d: RTL and testbench

//  Upstream feeder for the 2D write-DMA: packs a raster stream of P-bit pixels into D-bit words, line by line.
//  The partial last word of each line is zero-padded, so every line yields exactly ceil(width/K) words, K = D/P.
//  o_dout_* connects directly to the DMA's din port. The command is the same frame command given to the DMA.

---
 rtl/cory_pack2d_if.sv | 33 +++
 rtl/cory_pack2d.sv | 121 ++++++++++++
 tb/tb_cory_pack2d.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/cory_pack2d_if.sv
// Bus bundle for cory_pack2d: frame command, raster pixel stream in,
// packed word stream out. The slave modport is the packer's view, the
// master modport is the view of whatever drives the packer (source/sink).
//   cmd  : i_cmd_v / i_cmd_width / i_cmd_height -> o_cmd_r (frame-done ack)
//   pix  : i_pix_v / i_pix_d -> o_pix_r
//   dout : o_dout_v / o_dout_d / o_dout_l -> i_dout_r
interface cory_pack2d_if #(
  parameter int P = 8,
  parameter int D = 64,
  parameter int R = 11
);
  logic         i_cmd_v;
  logic [R-1:0] i_cmd_width;
  logic [R-1:0] i_cmd_height;
  logic         o_cmd_r;
  logic         i_pix_v;
  logic [P-1:0] i_pix_d;
  logic         o_pix_r;
  logic         o_dout_v;
  logic [D-1:0] o_dout_d;
  logic         o_dout_l;
  logic         i_dout_r;

  modport slave (
    input  i_cmd_v, i_cmd_width, i_cmd_height, i_pix_v, i_pix_d, i_dout_r,
    output o_cmd_r, o_pix_r, o_dout_v, o_dout_d, o_dout_l
  );

  modport master (
    output i_cmd_v, i_cmd_width, i_cmd_height, i_pix_v, i_pix_d, i_dout_r,
    input  o_cmd_r, o_pix_r, o_dout_v, o_dout_d, o_dout_l
  );
endinterface

// File: rtl/cory_pack2d.sv
// cory_pack2d: packs a raster stream of P-bit pixels into D-bit words,
// line by line, for the 2D write-DMA. Each line ends with a (possibly
// partial, zero-padded) word flagged o_dout_l, so a line always gives
// ceil(width/K) words, K = D/P. Pixel 0 of a word sits in bits [P-1:0].
// Ports:
//   clk   : clock, all state on posedge
//   reset : asynchronous active-high reset, aborts any frame in flight
//   bus   : cory_pack2d_if.slave (command, pixel in, packed word out)
module cory_pack2d #(
  parameter int P = 8,
  parameter int D = 64,
  parameter int R = 11
) (
  input  logic           clk,
  input  logic           reset,
  cory_pack2d_if.slave   bus
);
  localparam int K  = D / P;
  localparam int SW = $clog2(K);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state, state_nxt;
  logic [R-1:0]         width, height, pix_cnt, line_cnt;
  logic [SW-1:0]        slot;
  logic [K-1:0][P-1:0]  acc, acc_nxt;
  logic                 last_pend;
  logic                 dout_v, dout_l;
  logic [D-1:0]         dout_d;
  logic                 cmd_r, pix_r;
  logic                 hs_p, hs_d, eol, last_line, close;

  assign pix_r     = (state == RUN) & ~last_pend & (~dout_v | bus.i_dout_r);
  assign hs_p      = bus.i_pix_v & pix_r;
  assign hs_d      = dout_v & bus.i_dout_r;
  assign eol       = (pix_cnt == width - R'(1));
  assign last_line = (line_cnt == height - R'(1));
  assign close     = (slot == SW'(K - 1)) | eol;

  // Slot 0 opens a word: start from all-zero so unwritten slots of a
  // short last word come out as zero padding.
  always_comb begin
    acc_nxt       = (slot == '0) ? '0 : acc;
    acc_nxt[slot] = bus.i_pix_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_r     = 1'b0;
    case (state)
      IDLE: if (bus.i_cmd_v)
              state_nxt = (bus.i_cmd_width == '0 || bus.i_cmd_height == '0) ? DONE : RUN;
      // Output handshake with last_pend set can only be the frame's final word.
      RUN:  if (last_pend & hs_d) state_nxt = DONE;
      DONE: begin
        cmd_r     = bus.i_cmd_v;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      width     <= '0;
      height    <= '0;
      pix_cnt   <= '0;
      line_cnt  <= '0;
      slot      <= '0;
      acc       <= '0;
      last_pend <= 1'b0;
      dout_v    <= 1'b0;
      dout_l    <= 1'b0;
      dout_d    <= '0;
    end else begin
      if (state == IDLE && bus.i_cmd_v) begin
        width     <= bus.i_cmd_width;
        height    <= bus.i_cmd_height;
        pix_cnt   <= '0;
        line_cnt  <= '0;
        slot      <= '0;
        last_pend <= 1'b0;
      end
      if (state == DONE) last_pend <= 1'b0;

      if (hs_p) begin
        acc  <= acc_nxt;
        slot <= close ? '0 : slot + SW'(1);
        if (eol) begin
          pix_cnt  <= '0;
          line_cnt <= line_cnt + R'(1);
          if (last_line) last_pend <= 1'b1;
        end else begin
          pix_cnt <= pix_cnt + R'(1);
        end
      end

      // hs_p implies the output register is empty or draining this cycle,
      // so a closing pixel may overwrite it directly.
      if (hs_p && close) begin
        dout_v <= 1'b1;
        dout_d <= acc_nxt;
        dout_l <= eol;
      end else if (hs_d) begin
        dout_v <= 1'b0;
        dout_l <= 1'b0;
      end
    end
  end

  assign bus.o_cmd_r  = cmd_r;
  assign bus.o_pix_r  = pix_r;
  assign bus.o_dout_v = dout_v;
  assign bus.o_dout_d = dout_d;
  assign bus.o_dout_l = dout_l;
endmodule

// File: tb/tb_cory_pack2d.sv
// Bench for cory_pack2d (P=8, D=64, K=8): table of frames with
// hand-computed packed words, plus hand-written stall and reset sequences.
module tb_cory_pack2d;
  localparam int P = 8;
  localparam int D = 64;
  localparam int R = 11;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cory_pack2d_if #(.P(P), .D(D), .R(R)) bus ();
  cory_pack2d #(.P(P), .D(D), .R(R)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [R-1:0]     w;
    logic [R-1:0]     h;
    logic [7:0]       base;
    int               n;
    logic [3:0][63:0] wd;
    logic [3:0]       wl;
    bit               gap;
    int               stall_after;
    int               stall_len;
  } vec_t;

  vec_t tbl[7];

  function automatic vec_t mk(input int w, input int h, input logic [7:0] base, input int n,
                              input logic [63:0] w0, input logic [63:0] w1, input logic [63:0] w2,
                              input logic [3:0] l, input bit gap);
    vec_t v;
    v.w = R'(w); v.h = R'(h); v.base = base; v.n = n;
    v.wd[0] = w0; v.wd[1] = w1; v.wd[2] = w2; v.wd[3] = '0;
    v.wl = l; v.gap = gap; v.stall_after = -1; v.stall_len = 0;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Entered and left at posedge+1. Drives one frame command, streams its
  // pixels, collects words, checks flow control along the way.
  task automatic run_frame(input vec_t v);
    int ntot, idx, held, first_hs, last_hs, last_d_cyc, start_cyc, budget;
    bit done, stall_act, stall_done, prev_v, prev_r;
    logic [63:0] prev_d;
    logic [63:0] gw[$];
    logic        gl[$];
    ntot = int'(v.w) * int'(v.h);
    idx = 0; held = 0; first_hs = -1; last_hs = -1; last_d_cyc = -100; budget = 0;
    done = 0; stall_act = 0; stall_done = 0; prev_v = 0; prev_r = 1; prev_d = '0;
    gw.delete(); gl.delete();
    bus.i_cmd_v = 1'b1; bus.i_cmd_width = v.w; bus.i_cmd_height = v.h;
    bus.i_dout_r = 1'b1; bus.i_pix_v = (ntot > 0); bus.i_pix_d = v.base;
    start_cyc = cyc;
    while (!done && budget < 400) begin
      @(negedge clk);
      budget++;
      if (prev_v && !prev_r) begin
        check("hold_v", 64'(bus.o_dout_v), 64'd1);
        check("hold_d", bus.o_dout_d, prev_d);
      end
      if (bus.o_dout_v && !bus.i_dout_r) begin
        check("stall_pix_r", 64'(bus.o_pix_r), 64'd0);
        held++;
      end
      if (idx == ntot) check("no_extra_pix_r", 64'(bus.o_pix_r), 64'd0);
      prev_v = bus.o_dout_v; prev_r = bus.i_dout_r; prev_d = bus.o_dout_d;
      if (bus.o_dout_v && bus.i_dout_r) begin
        gw.push_back(bus.o_dout_d); gl.push_back(bus.o_dout_l); last_d_cyc = cyc;
      end
      if (bus.i_pix_v && bus.o_pix_r) begin
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc; idx++;
      end
      if (bus.o_cmd_r) begin
        done = 1;
        if (v.n > 0) check("cmd_r_latency", 64'(cyc - last_d_cyc), 64'd1);
        else         check("cmd_r_zero_frame", 64'(cyc - start_cyc <= 2), 64'd1);
      end
      if (!done) begin
        @(posedge clk); #1;
        bus.i_pix_v = (idx < ntot);
        bus.i_pix_d = v.base + 8'(idx);
        if (v.stall_after >= 0 && !stall_done && gw.size() >= v.stall_after) stall_act = 1;
        if (stall_act && held >= v.stall_len) begin stall_act = 0; stall_done = 1; end
        bus.i_dout_r = !stall_act;
      end
    end
    if (!done) check("frame_timeout", 64'd0, 64'd1);
    check("word_count", 64'(gw.size()), 64'(v.n));
    check("pix_count", 64'(idx), 64'(ntot));
    for (int i = 0; i < v.n && i < gw.size(); i++) begin
      check($sformatf("word%0d_d", i), gw[i], v.wd[i]);
      check($sformatf("word%0d_l", i), 64'(gl[i]), 64'(v.wl[i]));
    end
    if (v.stall_after < 0 && ntot > 0) check("pix_rate", 64'(last_hs - first_hs + 1), 64'(ntot));
    if (v.stall_after >= 0) check("stall_cycles", 64'(held), 64'(v.stall_len));
    @(posedge clk); #1;
    bus.i_pix_v = 1'b0; bus.i_dout_r = 1'b1;
    if (v.gap) begin
      bus.i_cmd_v = 1'b0;
      @(negedge clk);
      check("idle_cmd_r", 64'(bus.o_cmd_r), 64'd0);
      check("idle_dout_v", 64'(bus.o_dout_v), 64'd0);
      check("idle_pix_r", 64'(bus.o_pix_r), 64'd0);
      @(posedge clk); #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cmd_r"},  64'(bus.o_cmd_r), 64'd0);
    check({tag, "_pix_r"},  64'(bus.o_pix_r), 64'd0);
    check({tag, "_dout_v"}, 64'(bus.o_dout_v), 64'd0);
    check({tag, "_dout_l"}, 64'(bus.o_dout_l), 64'd0);
    check({tag, "_dout_d"}, bus.o_dout_d, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   cnt;
    // w=8,h=2 chained straight into w=10,h=1 (back-to-back commands)
    tbl[0] = mk(8, 2, 8'h00, 2, 64'h0706050403020100, 64'h0F0E0D0C0B0A0908, 64'h0, 4'b0011, 0);
    tbl[1] = mk(10, 1, 8'h10, 2, 64'h1716151413121110, 64'h0000000000001918, 64'h0, 4'b0010, 1);
    tbl[2] = mk(0, 4, 8'h00, 0, 64'h0, 64'h0, 64'h0, 4'b0000, 1);
    tbl[3] = mk(4, 0, 8'h00, 0, 64'h0, 64'h0, 64'h0, 4'b0000, 0);
    tbl[4] = mk(3, 2, 8'h20, 2, 64'h0000000000222120, 64'h0000000000252423, 64'h0, 4'b0011, 1);
    tbl[5] = mk(9, 1, 8'h30, 2, 64'h3736353433323130, 64'h0000000000000038, 64'h0, 4'b0010, 0);
    tbl[6] = mk(1, 3, 8'h40, 3, 64'h40, 64'h41, 64'h42, 4'b0111, 1);

    reset = 1'b1;
    bus.i_cmd_v = 1'b0; bus.i_cmd_width = '0; bus.i_cmd_height = '0;
    bus.i_pix_v = 1'b0; bus.i_pix_d = '0; bus.i_dout_r = 1'b1;
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 7; i++) run_frame(tbl[i]);

    // Output stall: sink holds off 5 cycles while word 1 is valid.
    v = mk(16, 1, 8'h10, 2, 64'h1716151413121110, 64'h1F1E1D1C1B1A1918, 64'h0, 4'b0010, 1);
    v.stall_after = 1; v.stall_len = 5;
    run_frame(v);

    // Reset in the middle of a line after 3 pixels.
    bus.i_cmd_v = 1'b1; bus.i_cmd_width = R'(8); bus.i_cmd_height = R'(1);
    bus.i_pix_v = 1'b1; bus.i_pix_d = 8'hA0; bus.i_dout_r = 1'b1;
    cnt = 0;
    for (int c = 0; c < 20 && cnt < 3; c++) begin
      @(negedge clk);
      if (bus.i_pix_v && bus.o_pix_r) cnt++;
      @(posedge clk); #1;
      bus.i_pix_d = 8'hA0 + 8'(cnt);
    end
    check("pre_reset_pix", 64'(cnt), 64'd3);
    bus.i_pix_v = 1'b0; bus.i_cmd_v = 1'b0; reset = 1'b1;
    @(negedge clk);
    check_all_zero("mid_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    run_frame(mk(8, 1, 8'h60, 1, 64'h6766656463626160, 64'h0, 64'h0, 4'b0001, 1));
    run_frame(mk(2, 1, 8'h70, 1, 64'h0000000000007170, 64'h0, 64'h0, 4'b0001, 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
